// File: rtl/prime_sweep_counter.sv
// prime_sweep_counter
// Drives a 3-input prime detector from a registered 3-bit counter. The counter
// is either single-stepped on rising edges of `step` or free-runs at one
// advance every PRESCALE clocks. The detector's prime flag is tallied per
// sweep, and the tally is reported on every wrap together with a one-cycle
// sweep_done pulse.
module prime_sweep_counter #(
    parameter int PRESCALE = 4          // clocks per advance in run mode, 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       run,
    input  logic       step,
    input  logic       up_dn,
    input  logic       prime_in,
    output logic       x3,
    output logic       x2,
    output logic       x1,
    output logic       busy,
    output logic       sweep_done,
    output logic [2:0] sweep_primes
);

    // Prescaler reload value. It is loaded on entry to and exit from RUN, on
    // every advance in RUN, and on clear, so that the first run-mode advance
    // lands exactly PRESCALE edges after run is first seen high.
    localparam logic [7:0] PRE_RELOAD = 8'(PRESCALE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] value_q, value_d;
    logic [2:0] tally_q, tally_d;
    logic [2:0] primes_q, primes_d;
    logic       done_q, done_d;
    logic       step_q;
    logic [7:0] pre_q, pre_d;

    logic       step_rise;
    logic       advance;
    logic       wrap;
    logic [2:0] value_adv;
    logic [2:0] tally_adv;

    // A single advance request comes from either the step edge (IDLE) or the
    // prescaler expiring (RUN); it is decided in the FSM block below.
    assign step_rise = step & ~step_q;

    // The value being left decides the wrap: 7 going up, 0 going down.
    assign wrap      = up_dn ? (value_q == 3'd7) : (value_q == 3'd0);
    assign value_adv = up_dn ? (value_q + 3'd1) : (value_q - 3'd1);

    // prime_in belongs to the value currently on x3..x1, i.e. the one being left.
    assign tally_adv = tally_q + {2'b00, prime_in};

    // Next-state logic: clear beats run, run beats step; advance bookkeeping follows.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        tally_d  = tally_q;
        primes_d = primes_q;
        done_d   = 1'b0;
        pre_d    = pre_q;
        advance  = 1'b0;

        if (clr) begin
            // Clear leaves the state alone but wipes every count and swallows
            // any advance that would otherwise have happened on this edge.
            value_d  = 3'd0;
            tally_d  = 3'd0;
            primes_d = 3'd0;
            pre_d    = PRE_RELOAD;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        // Entering RUN never advances; a simultaneous step
                        // edge is deliberately dropped.
                        state_d = ST_RUN;
                        pre_d   = PRE_RELOAD;
                    end else if (step_rise) begin
                        advance = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                        pre_d   = PRE_RELOAD;
                    end else if (pre_q == 8'd0) begin
                        advance = 1'b1;
                        pre_d   = PRE_RELOAD;
                    end else begin
                        pre_d = pre_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pre_d   = PRE_RELOAD;
                end
            endcase

            if (advance) begin
                value_d = value_adv;
                if (wrap) begin
                    // The last code's prime flag is folded straight into the
                    // report instead of going through the tally first.
                    primes_d = tally_adv;
                    tally_d  = 3'd0;
                    done_d   = 1'b1;
                end else begin
                    tally_d = tally_adv;
                end
            end
        end
    end

    // State and datapath registers; reset aborts a run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            value_q  <= 3'd0;
            tally_q  <= 3'd0;
            primes_q <= 3'd0;
            done_q   <= 1'b0;
            step_q   <= 1'b0;
            pre_q    <= PRE_RELOAD;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            tally_q  <= tally_d;
            primes_q <= primes_d;
            done_q   <= done_d;
            // The step history is kept in every state, so holding step high
            // through RUN and back to IDLE does not fake a new edge.
            step_q   <= step;
            pre_q    <= pre_d;
        end
    end

    // All outputs come straight from registers.
    assign x3           = value_q[2];
    assign x2           = value_q[1];
    assign x1           = value_q[0];
    assign busy         = (state_q == ST_RUN);
    assign sweep_done   = done_q;
    assign sweep_primes = primes_q;

endmodule

// File: tb/tb_prime_sweep_counter.sv
// Directed bench for prime_sweep_counter with a reference prime detector
// (primes 2, 3, 5, 7) closing the loop from x3..x1 back to prime_in.
module tb_prime_sweep_counter;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       run;
    logic       step;
    logic       up_dn;
    logic       prime_in;
    logic       x3, x2, x1;
    logic       busy;
    logic       sweep_done;
    logic [2:0] sweep_primes;
    logic [2:0] x;

    int checks = 0;
    int errors = 0;

    prime_sweep_counter #(.PRESCALE(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .run          (run),
        .step         (step),
        .up_dn        (up_dn),
        .prime_in     (prime_in),
        .x3           (x3),
        .x2           (x2),
        .x1           (x1),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .sweep_primes (sweep_primes)
    );

    assign x = {x3, x2, x1};

    // Reference 3-input prime detector.
    always_comb prime_in = (x == 3'd2) || (x == 3'd3) || (x == 3'd5) || (x == 3'd7);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (x !== 3'd0) begin errors++; $display("FAIL reset_x got %0d expected 0", x); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
        checks++; if (sweep_primes !== 3'd0) begin errors++; $display("FAIL reset_primes got %0d expected 0", sweep_primes); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b expected 0", sweep_done); end
        #10;
        rst_n = 1'b1;
        tick();
        run = 1'b1;
        repeat (13) tick();
        checks++; if (x !== 3'd3) begin errors++; $display("FAIL reset_prerun_x got %0d expected 3", x); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_prerun_busy got %0b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (x !== 3'd0) begin errors++; $display("FAIL reset_async_x got %0d expected 0", x); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy got %0b expected 0", busy); end
        checks++; if (sweep_primes !== 3'd0) begin errors++; $display("FAIL reset_async_primes got %0d expected 0", sweep_primes); end
        run = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (x !== 3'd0) begin errors++; $display("FAIL reset_release_x got %0d expected 0", x); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %0b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_step_up();
        logic [2:0] exp_x;
        up_dn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_x = 3'(i);
            step = 1'b1;
            tick();
            checks++; if (x !== exp_x) begin errors++; $display("FAIL step_up_x[%0d] got %0d expected %0d", i, x, exp_x); end
            checks++; if (sweep_done !== (i == 8)) begin errors++; $display("FAIL step_up_done[%0d] got %0b expected %0b", i, sweep_done, (i == 8)); end
            step = 1'b0;
            tick();
        end
        checks++; if (sweep_primes !== 3'd4) begin errors++; $display("FAIL step_up_primes got %0d expected 4", sweep_primes); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL step_up_done_drop got %0b expected 0", sweep_done); end
        $display("test_step_up done");
    endtask

    task automatic test_run();
        logic [2:0] exp_x;
        int done_cnt;
        done_cnt = 0;
        up_dn = 1'b1;
        run = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_entry_busy got %0b expected 1", busy); end
        checks++; if (x !== 3'd0) begin errors++; $display("FAIL run_entry_x got %0d expected 0", x); end
        for (int n = 1; n <= 36; n++) begin
            tick();
            exp_x = 3'((n / 4) % 8);
            checks++; if (x !== exp_x) begin errors++; $display("FAIL run_x[%0d] got %0d expected %0d", n, x, exp_x); end
            if (sweep_done === 1'b1) done_cnt++;
            if (n == 32) begin
                checks++; if (sweep_primes !== 3'd4) begin errors++; $display("FAIL run_primes got %0d expected 4", sweep_primes); end
                checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL run_done got %0b expected 1", sweep_done); end
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL run_done_count got %0d expected 1", done_cnt); end
        run = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_exit_busy got %0b expected 0", busy); end
        checks++; if (x !== 3'd1) begin errors++; $display("FAIL run_exit_x got %0d expected 1", x); end
        repeat (5) tick();
        checks++; if (x !== 3'd1) begin errors++; $display("FAIL run_frozen_x got %0d expected 1", x); end
        $display("test_run done");
    endtask

    task automatic test_down();
        logic [2:0] exp_x;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (x !== 3'd0) begin errors++; $display("FAIL down_clr_x got %0d expected 0", x); end
        checks++; if (sweep_primes !== 3'd0) begin errors++; $display("FAIL down_clr_primes got %0d expected 0", sweep_primes); end
        up_dn = 1'b0;
        step = 1'b1;
        tick();
        checks++; if (x !== 3'd7) begin errors++; $display("FAIL down_first_x got %0d expected 7", x); end
        checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL down_first_done got %0b expected 1", sweep_done); end
        checks++; if (sweep_primes !== 3'd0) begin errors++; $display("FAIL down_first_primes got %0d expected 0", sweep_primes); end
        step = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            exp_x = 3'(7 - i);
            step = 1'b1;
            tick();
            checks++; if (x !== exp_x) begin errors++; $display("FAIL down_x[%0d] got %0d expected %0d", i, x, exp_x); end
            checks++; if (sweep_done !== (i == 8)) begin errors++; $display("FAIL down_done[%0d] got %0b expected %0b", i, sweep_done, (i == 8)); end
            step = 1'b0;
            tick();
        end
        checks++; if (sweep_primes !== 3'd4) begin errors++; $display("FAIL down_primes got %0d expected 4", sweep_primes); end
        $display("test_down done");
    endtask

    task automatic test_step_run();
        // Held step in IDLE: counting down from 7 gives exactly one advance to 6.
        up_dn = 1'b0;
        step = 1'b1;
        tick();
        checks++; if (x !== 3'd6) begin errors++; $display("FAIL held_step_first_x got %0d expected 6", x); end
        repeat (9) tick();
        checks++; if (x !== 3'd6) begin errors++; $display("FAIL held_step_x got %0d expected 6", x); end
        step = 1'b0;
        tick();
        // Step toggling during RUN: only the prescaler advances.
        run = 1'b1;
        tick();
        for (int n = 1; n <= 12; n++) begin
            step = (n % 2) == 1;
            tick();
            if (n == 3) begin
                checks++; if (x !== 3'd6) begin errors++; $display("FAIL run_step_early_x got %0d expected 6", x); end
            end
        end
        checks++; if (x !== 3'd3) begin errors++; $display("FAIL run_step_x got %0d expected 3", x); end
        run = 1'b0;
        step = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_step_exit_busy got %0b expected 0", busy); end
        // run and a step edge together: enter RUN without advancing.
        run = 1'b1;
        step = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_edge_busy got %0b expected 1", busy); end
        checks++; if (x !== 3'd3) begin errors++; $display("FAIL same_edge_x got %0d expected 3", x); end
        repeat (3) tick();
        checks++; if (x !== 3'd3) begin errors++; $display("FAIL same_edge_wait_x got %0d expected 3", x); end
        tick();
        checks++; if (x !== 3'd2) begin errors++; $display("FAIL same_edge_adv_x got %0d expected 2", x); end
        run = 1'b0;
        step = 1'b0;
        tick();
        $display("test_step_run done");
    endtask

    task automatic test_clear();
        int done_cnt;
        done_cnt = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        up_dn = 1'b1;
        repeat (8) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        checks++; if (sweep_primes !== 3'd4) begin errors++; $display("FAIL clear_pre_primes got %0d expected 4", sweep_primes); end
        repeat (5) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        checks++; if (x !== 3'd5) begin errors++; $display("FAIL clear_pre_x got %0d expected 5", x); end
        run = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (x !== 3'd0) begin errors++; $display("FAIL clear_x got %0d expected 0", x); end
        checks++; if (sweep_primes !== 3'd0) begin errors++; $display("FAIL clear_primes got %0d expected 0", sweep_primes); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy got %0b expected 1", busy); end
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (sweep_done === 1'b1) done_cnt++;
            if (n == 4) begin
                checks++; if (x !== 3'd1) begin errors++; $display("FAIL clear_first_adv_x got %0d expected 1", x); end
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clear_done_count got %0d expected 1", done_cnt); end
        checks++; if (sweep_primes !== 3'd4) begin errors++; $display("FAIL clear_sweep_primes got %0d expected 4", sweep_primes); end
        checks++; if (x !== 3'd0) begin errors++; $display("FAIL clear_sweep_x got %0d expected 0", x); end
        run = 1'b0;
        tick();
        $display("test_clear done");
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        up_dn = 1'b1;
        test_reset();
        test_step_up();
        test_run();
        test_down();
        test_step_run();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
